// File: rtl/tdm_demux_4ch.sv
// tdm_demux_4ch: receive side of a 4-lane TDM bus; gathers slots 0..3 after a
// start-of-frame and publishes all four lanes together with a one-cycle valid pulse.
module tdm_demux_4ch #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic         in_sof,
    input  logic [N-1:0] in_data,
    output logic [N-1:0] O0,
    output logic [N-1:0] O1,
    output logic [N-1:0] O2,
    output logic [N-1:0] O3,
    output logic         frame_valid,
    output logic         frame_err,
    output logic [1:0]   slot
);
    typedef enum logic {IDLE, COLLECT} state_t;
    state_t state;
    logic [N-1:0] sh0, sh1, sh2;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            slot        <= 2'd0;
            sh0         <= '0;
            sh1         <= '0;
            sh2         <= '0;
            O0          <= '0;
            O1          <= '0;
            O2          <= '0;
            O3          <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            if (in_valid) begin
                if (in_sof) begin
                    // an sof mid-frame drops the partial frame and restarts at slot 1
                    frame_err <= (state == COLLECT);
                    sh0       <= in_data;
                    slot      <= 2'd1;
                    state     <= COLLECT;
                end else if (state == COLLECT) begin
                    if (slot == 2'd1) begin
                        sh1  <= in_data;
                        slot <= 2'd2;
                    end else if (slot == 2'd2) begin
                        sh2  <= in_data;
                        slot <= 2'd3;
                    end else begin
                        O0          <= sh0;
                        O1          <= sh1;
                        O2          <= sh2;
                        O3          <= in_data;
                        frame_valid <= 1'b1;
                        slot        <= 2'd0;
                        state       <= IDLE;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_tdm_demux_4ch.sv
// tb_tdm_demux_4ch: directed plus randomized checks of tdm_demux_4ch against a
// frame-list reference model.
module tb_tdm_demux_4ch;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_sof = 1'b0;
    logic [3:0] in_data = '0;
    logic [3:0] O0, O1, O2, O3;
    logic       frame_valid, frame_err;
    logic [1:0] slot;

    int errors = 0;
    int checks = 0;

    // model: words gathered for the frame in progress, and the last published frame
    int         len;
    logic [3:0] fr[4];
    logic [3:0] exp_o[4];
    logic       exp_fv, exp_fe;

    tdm_demux_4ch #(.N(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
        .in_data(in_data), .O0(O0), .O1(O1), .O2(O2), .O3(O3),
        .frame_valid(frame_valid), .frame_err(frame_err), .slot(slot)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        len = 0;
        for (int i = 0; i < 4; i++) begin
            fr[i]    = '0;
            exp_o[i] = '0;
        end
        exp_fv = 1'b0;
        exp_fe = 1'b0;
    endtask

    task automatic model_word(input logic v, input logic s, input logic [3:0] d);
        exp_fv = 1'b0;
        exp_fe = 1'b0;
        if (v) begin
            if (s) begin
                exp_fe = (len != 0);
                fr[0]  = d;
                len    = 1;
            end else if (len != 0) begin
                fr[len] = d;
                len++;
                if (len == 4) begin
                    exp_o  = fr;
                    exp_fv = 1'b1;
                    len    = 0;
                end
            end
        end
    endtask

    task automatic check(input string tag);
        logic [15:0] got_o, want_o;
        got_o  = {O0, O1, O2, O3};
        want_o = {exp_o[0], exp_o[1], exp_o[2], exp_o[3]};
        checks++;
        assert (got_o === want_o) else begin
            errors++;
            $error("FAIL %s lanes got %h expected %h", tag, got_o, want_o);
        end
        checks++;
        assert (frame_valid === exp_fv) else begin
            errors++;
            $error("FAIL %s frame_valid got %b expected %b", tag, frame_valid, exp_fv);
        end
        checks++;
        assert (frame_err === exp_fe) else begin
            errors++;
            $error("FAIL %s frame_err got %b expected %b", tag, frame_err, exp_fe);
        end
        checks++;
        assert (slot === 2'(len)) else begin
            errors++;
            $error("FAIL %s slot got %0d expected %0d", tag, slot, len);
        end
    endtask

    task automatic step(input logic v, input logic s, input logic [3:0] d, input string tag);
        in_valid = v;
        in_sof   = s;
        in_data  = d;
        @(posedge clk);
        model_word(v, s, d);
        #1;
        check(tag);
    endtask

    task automatic frame(input logic [15:0] w, input string tag);
        step(1, 1, w[15:12], tag);
        step(1, 0, w[11:8], tag);
        step(1, 0, w[7:4], tag);
        step(1, 0, w[3:0], tag);
    endtask

    task automatic async_reset(input string tag);
        #1 rst_n = 1'b0;
        model_reset();
        #1 check(tag);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1 check("reset");
        rst_n = 1'b1;
        frame(16'h5A26, "basic");
        step(0, 0, 4'h0, "basic_hold");
        step(1, 1, 4'h5, "gap");
        for (int i = 0; i < 3; i++) step(0, 0, 4'hC, "gap_idle");
        step(1, 0, 4'hA, "gap");
        step(1, 0, 4'h2, "gap");
        step(1, 0, 4'h6, "gap");
        step(1, 1, 4'h1, "early");
        step(1, 0, 4'h2, "early");
        frame(16'h9873, "restart");
        step(0, 0, 4'h0, "restart_hold");
        async_reset("reset_idle");
        step(1, 0, 4'hF, "idle_drop");
        step(1, 0, 4'hE, "idle_drop");
        frame(16'h1234, "b2b1");
        frame(16'h5678, "b2b2");
        step(0, 0, 4'h0, "b2b_hold");
        step(1, 1, 4'h3, "mid_reset");
        step(1, 0, 4'h4, "mid_reset");
        step(1, 0, 4'h5, "mid_reset");
        async_reset("reset_mid");
        step(0, 0, 4'h0, "after_reset");
        frame(16'hABCD, "post_reset");
        step(0, 0, 4'h0, "post_reset_hold");
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) async_reset("rand_reset");
            step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 2),
                 4'($urandom), "random");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
